// File: rtl/debounce_scheduler.sv
// Multi-channel switch debouncer: one shared prescaler strobes all channels,
// and each channel keeps only a small stability counter plus rise/fall pulses.
module debounce_scheduler #(
  parameter int N              = 4,
  parameter int CLK_DIV        = 50_000,
  parameter int STABLE_SAMPLES = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         enable_i,
  input  logic [N-1:0] sw_i,
  output logic         sample_tick_o,
  output logic [N-1:0] db_level_o,
  output logic [N-1:0] db_rise_o,
  output logic [N-1:0] db_fall_o
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CW = $clog2(STABLE_SAMPLES + 1);
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CNT_MAX   = CW'(STABLE_SAMPLES - 1);

  logic [PW-1:0] presc_reg;
  logic          tick_reg;
  logic [N-1:0]  sync1_reg;
  logic [N-1:0]  sync2_reg;
  logic [N-1:0]  level_reg;
  logic [N-1:0]  lvl_d_reg;
  logic          update;

  // Prescaler freezes with enable low; strobe follows the cycle holding PRESC_MAX.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      presc_reg <= '0;
      tick_reg  <= 1'b0;
    end else if (enable_i) begin
      if (presc_reg == PRESC_MAX) begin
        presc_reg <= '0;
        tick_reg  <= 1'b1;
      end else begin
        presc_reg <= presc_reg + PW'(1);
        tick_reg  <= 1'b0;
      end
    end else begin
      tick_reg <= 1'b0;
    end
  end

  // A strobe coinciding with a freshly dropped enable must not move channel state.
  assign update = tick_reg & enable_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
      lvl_d_reg <= '0;
    end else begin
      sync1_reg <= sw_i;
      sync2_reg <= sync1_reg;
      lvl_d_reg <= level_reg;
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_chan
    logic [CW-1:0] cnt_reg;

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        cnt_reg       <= '0;
        level_reg[gi] <= 1'b0;
      end else if (update) begin
        if (sync2_reg[gi] == level_reg[gi]) begin
          cnt_reg <= '0;
        end else if (cnt_reg == CNT_MAX) begin
          level_reg[gi] <= sync2_reg[gi];
          cnt_reg       <= '0;
        end else begin
          cnt_reg <= cnt_reg + CW'(1);
        end
      end
    end
  end

  assign sample_tick_o = tick_reg;
  assign db_level_o    = level_reg;
  assign db_rise_o     = level_reg & ~lvl_d_reg;
  assign db_fall_o     = ~level_reg & lvl_d_reg;

endmodule

// File: tb/tb_debounce_scheduler.sv
// Directed bench for debounce_scheduler with N=4, CLK_DIV=4, STABLE_SAMPLES=3.
module tb_debounce_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b1;
  logic [3:0] sw = 4'b0000;
  logic       tick;
  logic [3:0] level;
  logic [3:0] rise;
  logic [3:0] fall;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int tick_cnt = 0;
  int rise_cnt [4];
  int fall_cnt [4];
  int rise_at [4];
  int fall_at [4];

  debounce_scheduler #(.N(4), .CLK_DIV(4), .STABLE_SAMPLES(3)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .enable_i(enable),
    .sw_i(sw),
    .sample_tick_o(tick),
    .db_level_o(level),
    .db_rise_o(rise),
    .db_fall_o(fall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic clr();
    tick_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      rise_cnt[k] = 0;
      fall_cnt[k] = 0;
      rise_at[k]  = -1;
      fall_at[k]  = -1;
    end
  endtask

  // Advance one clock and sample on the falling edge, logging pulses.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (tick) tick_cnt++;
    for (int k = 0; k < 4; k++) begin
      if (rise[k]) begin
        rise_cnt[k]++;
        rise_at[k] = cyc;
      end
      if (fall[k]) begin
        fall_cnt[k]++;
        fall_at[k] = cyc;
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    clr();
    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_outputs", {19'd0, tick, level, rise, fall}, 32'd0);

    // Strobe cadence after release, quiet inputs
    rst = 1'b0;
    cyc = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      chk("tick_cadence", {31'd0, tick}, {31'd0, (cyc % 4) == 0});
      chk("quiet_db", {20'd0, level, rise, fall}, 32'd0);
    end
    $display("phase cadence: cyc=%0d", cyc);

    // Clean press on channel 0
    sw = 4'b0001;
    clr();
    run(20);
    chk("ch0_rise_cnt", rise_cnt[0], 1);
    chk("ch0_rise_at", rise_at[0], 53);
    chk("ch0_others_rise", rise_cnt[1] + rise_cnt[2] + rise_cnt[3], 0);
    chk("ch0_level", {28'd0, level}, 32'h1);
    $display("phase press ch0: level=%b", level);

    // Short glitch on channel 1, then clean press
    sw = 4'b0011;
    clr();
    run(6);
    sw = 4'b0001;
    run(14);
    chk("ch1_glitch_rise", rise_cnt[1], 0);
    chk("ch1_glitch_level", {28'd0, level}, 32'h1);
    sw = 4'b0011;
    clr();
    run(20);
    chk("ch1_press_rise_at", rise_at[1], 93);
    chk("ch1_press_rise_cnt", rise_cnt[1], 1);
    $display("phase glitch ch1: level=%b", level);

    // Bounce on channel 2 across strobes
    sw = 4'b0111;
    clr();
    run(6);
    sw = 4'b0011;
    run(4);
    sw = 4'b0111;
    run(20);
    chk("ch2_bounce_rise_cnt", rise_cnt[2], 1);
    chk("ch2_bounce_rise_at", rise_at[2], 121);
    sw = 4'b0011;
    clr();
    run(20);
    chk("ch2_fall_cnt", fall_cnt[2], 1);
    chk("ch2_fall_at", fall_at[2], 141);
    chk("ch2_level", {28'd0, level}, 32'h3);
    $display("phase bounce ch2: level=%b", level);

    // All channels together
    sw = 4'b0000;
    clr();
    run(20);
    chk("all_clear_level", {28'd0, level}, 32'h0);
    sw = 4'b1111;
    clr();
    run(20);
    for (int k = 0; k < 4; k++) begin
      chk("all_rise_cnt", rise_cnt[k], 1);
      chk("all_rise_at", rise_at[k], 181);
    end
    chk("all_level", {28'd0, level}, 32'hf);
    $display("phase all: level=%b", level);

    // Enable pause after two strobes of a pending release
    sw = 4'b0000;
    clr();
    run(8);
    enable = 1'b0;
    clr();
    run(20);
    chk("pause_ticks", tick_cnt, 0);
    chk("pause_level", {28'd0, level}, 32'hf);
    chk("pause_falls", fall_cnt[0] + fall_cnt[1] + fall_cnt[2] + fall_cnt[3], 0);
    enable = 1'b1;
    clr();
    run(12);
    for (int k = 0; k < 4; k++) begin
      chk("resume_fall_at", fall_at[k], 221);
      chk("resume_fall_cnt", fall_cnt[k], 1);
    end
    chk("resume_ticks", tick_cnt, 3);
    $display("phase pause: level=%b", level);

    // Reset in the middle of a count with level 0101
    sw = 4'b0101;
    clr();
    run(20);
    chk("pre_reset_level", {28'd0, level}, 32'h5);
    sw = 4'b1010;
    run(8);
    rst = 1'b1;
    #1;
    chk("reset_immediate", {19'd0, tick, level, rise, fall}, 32'd0);
    clr();
    run(3);
    chk("reset_hold_falls", fall_cnt[0] + fall_cnt[2], 0);
    chk("reset_hold_outputs", {19'd0, tick, level, rise, fall}, 32'd0);
    rst = 1'b0;
    cyc = 0;
    clr();
    step();
    chk("post_release_outputs", {19'd0, tick, level, rise, fall}, 32'd0);
    run(19);
    chk("post_reset_ch1_rise_at", rise_at[1], 13);
    chk("post_reset_ch3_rise_at", rise_at[3], 13);
    chk("post_reset_ch0_rise", rise_cnt[0], 0);
    chk("post_reset_falls", fall_cnt[0] + fall_cnt[1] + fall_cnt[2] + fall_cnt[3], 0);
    chk("post_reset_level", {28'd0, level}, 32'ha);
    $display("phase reset: level=%b", level);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/debounce_scheduler.md
Name: debounce_scheduler

Overview:
- Multi-channel switch/button conditioner. One shared prescaler issues periodic sample strobes to N channels. Each channel keeps only a small stability counter, instead of a full-width timer per input.
- Sits between the board push-buttons/switches and the FIFO demo control logic (write/read/reset buttons, data switches).
- Delivers a clean level plus one-cycle rise and fall pulses per channel.

Parameters:
- N, 4, number of input channels (>=1).
- CLK_DIV, 50_000, clock cycles per sample strobe (>=2); 1 ms at 50 MHz.
- STABLE_SAMPLES, 8, consecutive differing samples required to accept a new level (>=1).

Ports:
- clk_i  input  1  system clock
- rst_i  input  1  asynchronous reset, active-high
- enable_i  input  1  1 = scheduler runs; 0 = prescaler and all channel state frozen
- sw_i  input  N  raw asynchronous switch inputs, bit k = channel k
- sample_tick_o  output  1  one-cycle strobe, shared sample instant
- db_level_o  output  N  debounced level per channel
- db_rise_o  output  N  one-cycle pulse on 0->1 of db_level_o[k]
- db_fall_o  output  N  one-cycle pulse on 1->0 of db_level_o[k]

Behaviour:
- Reset (async, rst_i=1):
  - Prescaler, both synchroniser stages, all channel counters, db_level_o and the level-delay register clear to 0.
  - All outputs read 0 during reset and in the first cycle after release.
- Synchroniser: each sw_i[k] passes through a 2-FF chain every clock, independent of enable_i. sync[k] is the second stage.
- Prescaler:
  - Width $clog2(CLK_DIV); counts 0..CLK_DIV-1 and wraps to 0.
  - sample_tick_o is registered and high for exactly the one cycle after the prescaler held CLK_DIV-1. First strobe comes CLK_DIV cycles after reset release (with enable_i=1).
  - enable_i=0: prescaler holds its value, sample_tick_o=0. Counting resumes from the held value when enable_i returns to 1.
- Channel update: state changes only in cycles where sample_tick_o=1. Per channel k, with cnt[k] of width $clog2(STABLE_SAMPLES+1):
  - sync[k]==db_level_o[k]: cnt[k]<=0 (any bounce back restarts the count).
  - sync[k]!=db_level_o[k] and cnt[k]==STABLE_SAMPLES-1: db_level_o[k]<=sync[k], cnt[k]<=0.
  - otherwise: cnt[k]<=cnt[k]+1.
  - STABLE_SAMPLES=1: level follows sync at every strobe.
- Edge outputs:
  - lvl_d <= db_level_o every clock.
  - db_rise_o = db_level_o & ~lvl_d; db_fall_o = ~db_level_o & lvl_d. Each pulses exactly 1 cycle, in the cycle after the level register updates.
- Latency:
  - Input change to level change: 2 clocks of sync, plus wait to the next strobe, plus (STABLE_SAMPLES-1) further strobes.
  - Worst case 2 + STABLE_SAMPLES*CLK_DIV + 1 cycles; best case > 2 + (STABLE_SAMPLES-1)*CLK_DIV.
- Channels are fully independent. Simultaneous acceptance on several channels in the same strobe is legal, and their rise/fall pulses coincide.
- Reset mid-count: all counters and levels clear immediately. No rise/fall pulse is produced by reset itself.
- Counters never exceed STABLE_SAMPLES-1, so no wrap.

Test Plan (N=4, CLK_DIV=4, STABLE_SAMPLES=3):
- Reset, sw_i=0 held 40 cycles -> sample_tick_o every 4th cycle, first in cycle 4 after release; all db outputs stay 0.
- sw_i[0] 0->1 held -> db_level_o[0]=1 after the 3rd strobe that sees sync=1; db_rise_o[0] high exactly 1 cycle, the cycle after the level update; other channels 0.
- sw_i[1] pulse lasting 6 cycles (2 strobes max) -> db_level_o[1] stays 0, no pulses; cnt reset confirmed by a later clean 3-strobe press accepted.
- Bounce on sw_i[2] (1,0,1 across successive strobes, then held 1) -> level rises only 3 strobes after the final 0->1; single db_rise_o pulse. Release held -> single db_fall_o pulse.
- sw_i[3:0]=4'b1111 at once -> all db_level_o bits rise on the same strobe; db_rise_o=4'b1111 for 1 cycle.
- enable_i=0 mid-count (2 strobes seen) for 20 cycles -> no strobes, level unchanged. Re-enable -> acceptance on the next strobe.
- rst_i asserted mid-count with db_level_o=4'b0101 -> all outputs 0 immediately; no db_fall_o pulse.
